instr_encoder_loader: RTL

- Encoder counterpart to the processor's opcode/instruction decoder.
- Accepts instruction fields (opcode, registers, ALU op, immediate, target) over a valid/ready stream and packs them into 32-bit ISA words.
- Writes the packed words sequentially into instruction memory starting at a programmable base address.
- Used by the boot/program-load path and by the verification harness to build test programs in hardware.

---
 rtl/instr_encoder_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Packs instruction field bundles into 32-bit ISA words and writes them to
// consecutive instruction-memory addresses starting at a base set by start.
module instr_encoder_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    input  logic [26:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic [ADDR_W:0]   count,
    output logic              illegal,
    output logic              done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FULL = 2'd3
    } state_t;

    // Count value just before the write that lands on base_addr+DEPTH-1.
    localparam logic [ADDR_W:0] LP_LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    state_t              r_state;
    logic                r_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data;
    logic [ADDR_W:0]     r_count;
    logic                r_illegal;
    logic                r_done;
    logic [ADDR_W-1:0]   r_next_addr;

    logic [31:0]         w_word;
    logic                w_legal;
    logic                w_fire;

    always_comb begin
        w_word  = 32'd0;
        w_legal = 1'b1;
        case (in_op)
            5'd0:                          w_word = {in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
            5'd2, 5'd5, 5'd6, 5'd7, 5'd8:  w_word = {in_op, in_rd, in_rs, in_imm};
            5'd1, 5'd3, 5'd9, 5'd10:       w_word = {in_op, in_target};
            5'd4:                          w_word = {in_op, in_rd, 22'd0};
            default:                       w_legal = 1'b0;
        endcase
    end

    // Valid/ready: a bundle transfers on a rising edge where in_valid and
    // in_ready are both high; the producer holds fields while in_ready is low.
    assign w_fire = in_valid && r_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= 32'd0;
            r_count     <= '0;
            r_illegal   <= 1'b0;
            r_done      <= 1'b0;
            r_next_addr <= '0;
        end else if (start) begin
            // A handshake coinciding with start is dropped.
            r_state     <= ST_RUN;
            r_ready     <= 1'b1;
            r_we        <= 1'b0;
            r_count     <= '0;
            r_illegal   <= 1'b0;
            r_done      <= 1'b0;
            r_next_addr <= base_addr;
        end else begin
            r_we <= 1'b0;
            if (w_fire) begin
                if (w_legal) begin
                    r_we        <= 1'b1;
                    r_addr      <= r_next_addr;
                    r_data      <= w_word;
                    r_next_addr <= r_next_addr + 1'b1;
                    r_count     <= r_count + 1'b1;
                end else begin
                    r_illegal <= 1'b1;
                end
                if (w_legal && (r_count == LP_LAST_CNT)) begin
                    r_state <= ST_FULL;
                    r_ready <= 1'b0;
                    r_done  <= 1'b1;
                end else if (in_last) begin
                    r_state <= ST_DONE;
                    r_ready <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = r_ready;
    assign imem_we   = r_we;
    assign imem_addr = r_addr;
    assign imem_data = r_data;
    assign count     = r_count;
    assign illegal   = r_illegal;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule
